l4_status_reader: RTL and testbench
===================================

// Module: l4_status_reader
// PURPOSE
//  Host-side read-out engine for L4 status/result registers. On a read request it
//  takes a coherent snapshot of a wide status vector, then streams it to the PCI
//  target logic as 32-bit words over a valid/ready handshake.
//  It sits between the L4 datapath status registers and the PCI read-data mux.
// PARAMETERS
//  WBITS   32  width of one output word
//  NWORDS  4   number of words in status_in
//  AW      2   word-address width; NWORDS <= 2**AW required
// PORTS
//  clk        in   1             system clock, rising edge
//  resetn     in   1             asynchronous active-low reset
//  status_in  in   NWORDS*WBITS  live status vector; word k = bits [k*WBITS +: WBITS]
//  rd_req     in   1             start request, sampled only in IDLE
//  rd_addr    in   AW            first word index
//  rd_len     in   AW+1          number of words to send (0..2**(AW+1)-1)
//  rd_abort   in   1             terminate transfer in progress
//  dout       out  WBITS         current output word
//  dout_valid out  1             dout holds a valid word
//  dout_ready in   1             consumer accepts dout this cycle
//  busy       out  1             transfer in progress (SEND state)
//  done       out  1             one-cycle pulse, transfer completed normally
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE; dout=0, dout_valid=0, busy=0, done=0;
//   snapshot, word pointer and remaining count cleared. Reset mid-transfer
//   discards the transfer; no done pulse.
//  States: IDLE, SEND, DONE.
//  IDLE: rd_req=1 and rd_len!=0 -> capture status_in into snapshot, ptr<=rd_addr,
//   rem<=rd_len, go SEND. rd_req=1 and rd_len==0 -> go DONE, no snapshot taken.
//  SEND: busy=1, dout_valid=1, dout=snapshot word[ptr]. Latency: rd_req sampled at
//   edge N -> dout_valid=1 from edge N+1.
//   Transfer occurs on a clock edge where dout_valid && dout_ready.
//   On transfer: rem<=rem-1; ptr<=ptr+1, wrapping to 0 after NWORDS-1;
//   rd_addr>=NWORDS is first reduced modulo NWORDS.
//   Last transfer (rem==1) -> DONE.
//   rd_len>NWORDS: words repeat cyclically from the same snapshot, never re-sampled.
//  dout, dout_valid hold stable while dout_valid && !dout_ready.
//  DONE: done=1 for exactly one cycle, dout_valid=0, busy=0 -> IDLE.
//  rd_abort in SEND: -> IDLE at that edge, dout_valid=0 next cycle, no done pulse.
//   Abort coinciding with a transfer: word counts as taken, transfer still aborts.
//   rd_abort in IDLE/DONE is ignored.
//  rd_req while not IDLE is ignored, not queued. Back-to-back: a new rd_req is
//   accepted in the IDLE cycle that follows DONE.
//  status_in changes after capture never affect dout.
// CONFIGURATION
//  L4_RDBK_PARITY_EN defined: adds output dout_par (1 bit, even parity: XOR of
//   dout), valid with dout_valid, reset value 0, registered alongside dout.
//  Not defined: port absent; no parity logic.
// TESTING
//  1 Reset: resetn=0 mid-SEND -> all outputs 0 immediately (async); no done pulse.
//  2 NWORDS=4, status_in words {W3..W0}={D,C,B,A}, rd_addr=1, rd_len=3,
//    dout_ready=1 -> B,C,D on 3 consecutive cycles; done on 4th cycle.
//  3 Same request, rd_addr=3, rd_len=6 -> D,A,B,C,D,A; change status_in after
//    rd_req -> output still shows snapshot values.
//  4 dout_ready=0 for 5 cycles after first valid -> dout stable, rem unchanged;
//    ready=1 -> sequence resumes without loss or duplication.
//  5 rd_len=0 -> done pulse 1 cycle after rd_req, dout_valid never 1;
//    rd_abort on 2nd word with ready=1 -> 2 words taken, no done, busy=0 next cycle.
//  6 L4_RDBK_PARITY_EN: dout=32'h0000_0007 -> dout_par=1; dout=32'h0000_0003 -> 0.

Source files
------------

// File: rtl/l4_status_reader.sv
// Snapshot-and-stream read-out engine for wide L4 status registers.
// Optional macro L4_RDBK_PARITY_EN adds a registered even-parity output dout_par.
module l4_status_reader #(
  parameter int WBITS  = 32,
  parameter int NWORDS = 4,
  parameter int AW     = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NWORDS*WBITS-1:0] status_in,
  input  logic                    rd_req,
  input  logic [AW-1:0]           rd_addr,
  input  logic [AW:0]             rd_len,
  input  logic                    rd_abort,
  output logic [WBITS-1:0]        dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
`ifdef L4_RDBK_PARITY_EN
  output logic                    dout_par,
`endif
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WBITS-1:0]  snap_q [NWORDS];
  logic [WBITS-1:0]  liveWords [NWORDS];
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [AW:0]       rem_q, rem_d;
  logic [WBITS-1:0]  dout_q, dout_d;
  logic              capture;
  logic [AW-1:0]     startPtr;
  logic [AW-1:0]     nextPtr;

  function automatic logic [AW-1:0] wrapAddr(input logic [AW-1:0] a);
    return AW'(32'(a) % NWORDS);
  endfunction

  always_comb begin
    for (int k = 0; k < NWORDS; k++) begin
      liveWords[k] = status_in[k*WBITS +: WBITS];
    end
  end

  assign startPtr = wrapAddr(rd_addr);
  assign nextPtr  = (ptr_q == AW'(NWORDS-1)) ? '0 : ptr_q + 1'b1;

  // The next output word is decided here so dout can be a plain register:
  // loaded from the live vector at capture, then from the snapshot per transfer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    dout_d  = dout_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          if (rd_len != '0) begin
            capture = 1'b1;
            ptr_d   = startPtr;
            rem_d   = rd_len;
            dout_d  = liveWords[startPtr];
            state_d = SEND;
          end else begin
            state_d = DONE;
          end
        end
      end
      SEND: begin
        if (dout_ready) begin
          rem_d = rem_q - 1'b1;
          ptr_d = nextPtr;
          if (rem_q == (AW+1)'(1)) begin
            state_d = DONE;
            dout_d  = '0;
          end else begin
            dout_d  = snap_q[nextPtr];
          end
        end
        if (rd_abort) begin
          state_d = IDLE;
          dout_d  = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        dout_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      dout_q  <= '0;
      for (int k = 0; k < NWORDS; k++) begin
        snap_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      dout_q  <= dout_d;
      if (capture) begin
        for (int k = 0; k < NWORDS; k++) begin
          snap_q[k] <= liveWords[k];
        end
      end
    end
  end

`ifdef L4_RDBK_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^dout_d;
    end
  end

  assign dout_par = par_q;
`endif

  assign dout       = dout_q;
  assign dout_valid = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_l4_status_reader.sv
// Self-checking bench for l4_status_reader: request table plus word scoreboard,
// with hand-written reset, idle-abort and back-to-back sequences.
module tb_l4_status_reader;

  logic          clk;
  logic          resetn;
  logic [127:0]  status_in;
  logic          rd_req;
  logic [1:0]    rd_addr;
  logic [2:0]    rd_len;
  logic          rd_abort;
  logic [31:0]   dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;
  logic          done;
`ifdef L4_RDBK_PARITY_EN
  logic          dout_par;
`endif

  l4_status_reader dut (
    .clk        (clk),
    .resetn     (resetn),
    .status_in  (status_in),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_len     (rd_len),
    .rd_abort   (rd_abort),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
`ifdef L4_RDBK_PARITY_EN
    .dout_par   (dout_par),
`endif
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] addr;
    logic [2:0] len;
    int         abortAfter;
    int         stall;
    int         expDone;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] baseWords[4];
  logic [31:0] expQ[$];
  int          checks = 0;
  int          errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic loadStatus();
    status_in = {baseWords[3], baseWords[2], baseWords[1], baseWords[0]};
  endtask

  // Drive one request, push the words it must produce, and retire them as the DUT hands them over.
  task automatic applyStimulus(input vec_t v);
    int  nTake, taken, doneCount, cycles, stallLeft;
    bit  started;
    logic [31:0] expWord;
    taken = 0; doneCount = 0; cycles = 0; started = 0;
    stallLeft = v.stall;
    nTake = (v.abortAfter > 0) ? v.abortAfter : int'(v.len);
    expQ.delete();
    for (int i = 0; i < nTake; i++) begin
      expQ.push_back(baseWords[(int'(v.addr) + i) % 4]);
    end
    loadStatus();
    rd_req = 1'b1; rd_addr = v.addr; rd_len = v.len; dout_ready = 1'b1; rd_abort = 1'b0;
    @(posedge clk); #1;
    rd_req = 1'b0;
    status_in = ~{baseWords[3], baseWords[2], baseWords[1], baseWords[0]};
    forever begin
      @(negedge clk);
      rd_abort = 1'b0;
      rd_req = 1'b0;
      if (dout_valid && stallLeft > 0) begin
        dout_ready = 1'b0;
        rd_req = 1'b1; rd_addr = 2'd0; rd_len = 3'd1;
        stallLeft--;
      end else begin
        dout_ready = 1'b1;
      end
      #1;
      if (busy || done) started = 1;
      if (done) doneCount++;
      if (dout_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_valid", {31'd0, dout_valid}, 32'd0);
        end else begin
          expWord = expQ[0];
          checkOutput("dout_word", dout, expWord);
`ifdef L4_RDBK_PARITY_EN
          checkOutput("dout_par", {31'd0, dout_par}, {31'd0, ^expWord});
`endif
          if (dout_ready) begin
            void'(expQ.pop_front());
            taken++;
            if (v.abortAfter > 0 && taken == v.abortAfter) rd_abort = 1'b1;
          end
        end
      end
      if (started && !busy && !done) break;
      cycles++;
      if (cycles > 40) begin
        checkOutput("timeout", 32'(cycles), 32'd40);
        break;
      end
    end
    checkOutput("words_left", 32'(expQ.size()), 32'd0);
    checkOutput("done_count", 32'(doneCount), 32'(v.expDone));
    rd_req = 1'b0;
    dout_ready = 1'b1;
  endtask

  initial begin
    int badIdle;
    vecs[0] = '{addr: 2'd1, len: 3'd3, abortAfter: 0, stall: 0, expDone: 1};
    vecs[1] = '{addr: 2'd3, len: 3'd6, abortAfter: 0, stall: 0, expDone: 1};
    vecs[2] = '{addr: 2'd0, len: 3'd2, abortAfter: 0, stall: 5, expDone: 1};
    vecs[3] = '{addr: 2'd2, len: 3'd0, abortAfter: 0, stall: 0, expDone: 1};
    vecs[4] = '{addr: 2'd0, len: 3'd4, abortAfter: 2, stall: 0, expDone: 0};
    vecs[5] = '{addr: 2'd2, len: 3'd7, abortAfter: 0, stall: 0, expDone: 1};
    vecs[6] = '{addr: 2'd3, len: 3'd1, abortAfter: 0, stall: 3, expDone: 1};
    vecs[7] = '{addr: 2'd1, len: 3'd5, abortAfter: 1, stall: 2, expDone: 0};
    baseWords[0] = 32'hAAAA_0001;
    baseWords[1] = 32'hBBBB_0012;
    baseWords[2] = 32'hCCCC_0123;
    baseWords[3] = 32'hDDDD_1234;

    resetn = 1'b0; rd_req = 1'b0; rd_addr = '0; rd_len = '0; rd_abort = 1'b0; dout_ready = 1'b1;
    loadStatus();
    #12;
    checkOutput("reset_dout", dout, 32'd0);
    checkOutput("reset_valid", {31'd0, dout_valid}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Abort while idle must be ignored.
    @(negedge clk);
    rd_abort = 1'b1;
    @(negedge clk);
    rd_abort = 1'b0;
    #1;
    checkOutput("idle_abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_abort_done", {31'd0, done}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
    end

`ifdef L4_RDBK_PARITY_EN
    baseWords[0] = 32'h0000_0007;
    baseWords[1] = 32'h0000_0003;
    applyStimulus('{addr: 2'd0, len: 3'd2, abortAfter: 0, stall: 0, expDone: 1});
`endif

    // Asynchronous reset in the middle of a long transfer.
    @(negedge clk);
    loadStatus();
    rd_req = 1'b1; rd_addr = 2'd0; rd_len = 3'd7;
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk); #1;
    checkOutput("pre_reset_valid", {31'd0, dout_valid}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("async_rst_dout", dout, 32'd0);
    checkOutput("async_rst_valid", {31'd0, dout_valid}, 32'd0);
    checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("async_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    badIdle = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (done || busy || dout_valid) badIdle++;
    end
    checkOutput("post_reset_idle", 32'(badIdle), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
